round_robin_arbiter_with_lock: RTL and testbench
================================================

ROUND_ROBIN_ARBITER_WITH_LOCK -- requirements
Module: round_robin_arbiter_with_lock

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning number of requesters (legal 2..8).
REQ-002 The module SHALL have parameter MAX_HOLD, default 8, meaning maximum consecutive cycles one grant is held (legal 2..255).
REQ-003 The module SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 The module SHALL have port req  input  N  per-requester request level, held for the whole transaction.
REQ-006 The module SHALL have port done  input  N  per-requester end-of-transaction pulse, honoured only from the current owner.
REQ-007 The module SHALL have port grant  output  N  registered one-hot grant, or all zeros.
REQ-008 The module SHALL have port grant_valid  output  1  registered, equals |grant.
REQ-009 The module SHALL have port grant_id  output  $clog2(N)  registered index of owner, 0 when grant_valid=0.
REQ-010 The module SHALL have port timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-011 The module SHALL implement two states: IDLE (no owner) and BUSY (one owner, grant held).
REQ-012 Internal state SHALL be: state, owner index, rotating pointer ptr (0..N-1), hold counter hcnt (0..MAX_HOLD-1).
REQ-013 Arbitration SHALL select the first set bit of req scanning ptr, ptr+1, ... wrapping modulo N.
REQ-014 In IDLE, if req!=0 at a rising edge, the winner SHALL be granted at that edge (grant visible the following cycle, 1-cycle latency), state->BUSY, hcnt->0.
REQ-015 In IDLE with req==0, grant SHALL stay 0 and ptr SHALL not change.
REQ-016 In BUSY, grant SHALL stay on the owner, independent of other requests, while no release condition holds; hcnt increments by 1 per cycle.
REQ-017 Release conditions (evaluated each edge in BUSY): done[owner]=1; req[owner]=0; or hcnt==MAX_HOLD-1 (forced).
REQ-018 On release, ptr SHALL become (owner+1) mod N, and arbitration SHALL run in the same edge with that new ptr over current req.
REQ-019 If that arbitration finds a winner, grant SHALL move to it at the same edge (no idle bubble), hcnt->0, state stays BUSY; otherwise grant->0, state->IDLE.
REQ-020 The released owner SHALL be re-granted only if no other requester is active (it is last in rotation order).
REQ-021 A re-grant to the same owner SHALL restart hcnt at 0; grant stays continuously high.
REQ-022 timeout SHALL be 1 for exactly the cycle after an edge where release was forced by hcnt only; done[owner]=1 or req[owner]=0 at that edge suppresses timeout.
REQ-023 done bits of non-owners and done asserted in IDLE SHALL be ignored.
REQ-024 grant SHALL never have more than one bit set; grant_id and grant SHALL always agree.
REQ-025 Grant SHALL be held for at most MAX_HOLD consecutive cycles per award.

Reset
REQ-026 While rst=0, outputs SHALL be grant=0, grant_valid=0, grant_id=0, timeout=0, immediately (asynchronous), including mid-transaction.
REQ-027 While rst=0, state=IDLE, ptr=0, hcnt=0, owner=0.
REQ-028 After rst rises, first arbitration SHALL occur at the first rising edge with rst=1.

Verification
REQ-029 Rotation: N=4, req=1111 constant, done pulsed by owner each 2nd granted cycle -> grant sequence 0001,0010,0100,1000,0001, two cycles each, no bubbles.
REQ-030 Lock: owner 0 granted, req=0011, no done -> grant stays 0001 for 8 cycles, then 0010, timeout=1 for one cycle with it.
REQ-031 Sole requester timeout: req=0001 only, no done -> grant 0001 continuously, timeout pulses every 8 cycles.
REQ-032 Release by drop: owner 2 drops req[2], req=0001 -> grant 0001 next cycle, timeout=0, ptr wraps correctly (3->0).
REQ-033 Idle/stray done: req=0000, done=1111 -> grant stays 0000, ptr unchanged; then req=0100 -> grant 0100 one cycle later.
REQ-034 Mid-operation reset: rst=0 while grant=0100 -> grant=0 without clock edge; after release, req=1100 -> grant 0100 (ptr=0 restart).

Source files
------------

// File: rtl/round_robin_arbiter_with_lock.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter_with_lock
// Description : Round-robin arbiter that holds a grant until done, request
//               drop or a hold-count timeout; release re-arbitrates same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter_with_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout
);

  localparam int c_iw = $clog2(N);
  localparam int c_hw = $clog2(MAX_HOLD);
  localparam logic [c_hw-1:0] c_hmax = c_hw'(MAX_HOLD - 1);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_busy = 1'b1;

  logic [0:0]      r_state;
  logic [c_iw-1:0] r_owner;
  logic [c_iw-1:0] r_ptr;
  logic [c_hw-1:0] r_hcnt;
  logic [N-1:0]    r_grant;
  logic            r_grant_valid;
  logic [c_iw-1:0] r_grant_id;
  logic            r_timeout;

  logic [0:0]      w_state_nxt;
  logic [c_iw-1:0] w_owner_nxt;
  logic [c_iw-1:0] w_ptr_nxt;
  logic [c_hw-1:0] w_hcnt_nxt;
  logic [N-1:0]    w_grant_nxt;
  logic            w_grant_valid_nxt;
  logic [c_iw-1:0] w_grant_id_nxt;
  logic            w_timeout_nxt;

  logic            w_busy;
  logic            w_hold_expired;
  logic            w_owner_quits;
  logic            w_release;
  logic [c_iw-1:0] w_owner_inc;
  logic [c_iw-1:0] w_arb_ptr;
  logic            w_win_found;
  logic [c_iw-1:0] w_win;

  assign w_busy         = (r_state == c_busy);
  assign w_hold_expired = (r_hcnt == c_hmax);
  assign w_owner_quits  = done[r_owner] | ~req[r_owner];
  assign w_release      = w_busy & (w_owner_quits | w_hold_expired);
  assign w_owner_inc    = c_iw'((int'(r_owner) + 1) % N);
  // On release the scan starts just past the old owner, so it comes last.
  assign w_arb_ptr      = w_release ? w_owner_inc : r_ptr;

  always_comb begin
    w_win_found = 1'b0;
    w_win       = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_win_found && req[(int'(w_arb_ptr) + i) % N]) begin
        w_win_found = 1'b1;
        w_win       = c_iw'((int'(w_arb_ptr) + i) % N);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= c_idle;
      r_owner       <= '0;
      r_ptr         <= '0;
      r_hcnt        <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hcnt        <= w_hcnt_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      c_idle: begin
        if (w_win_found) begin
          w_state_nxt = c_busy;
          w_owner_nxt = w_win;
          w_hcnt_nxt  = '0;
        end
      end
      c_busy: begin
        if (w_release) begin
          w_ptr_nxt  = w_owner_inc;
          w_hcnt_nxt = '0;
          if (w_win_found) begin
            w_owner_nxt = w_win;
          end else begin
            w_state_nxt = c_idle;
            w_owner_nxt = '0;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + c_hw'(1);
        end
      end
      default: begin
        w_state_nxt = c_idle;
        w_owner_nxt = '0;
        w_ptr_nxt   = '0;
        w_hcnt_nxt  = '0;
      end
    endcase
  end

  // Output logic, computed from the next state so outputs are registered
  always_comb begin
    w_grant_nxt       = '0;
    w_grant_valid_nxt = 1'b0;
    w_grant_id_nxt    = '0;
    w_timeout_nxt     = w_busy & w_hold_expired & ~w_owner_quits;
    if (w_state_nxt == c_busy) begin
      w_grant_nxt       = N'(1) << w_owner_nxt;
      w_grant_valid_nxt = 1'b1;
      w_grant_id_nxt    = w_owner_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter_with_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_robin_arbiter_with_lock
// Description : Directed scoreboard bench for round_robin_arbiter_with_lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter_with_lock;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected {grant, grant_valid, grant_id, timeout} after each edge
  logic [7:0] exp_q [$];

  round_robin_arbiter_with_lock #(.N(4), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] onehot_id(input logic [3:0] g);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
    return id;
  endfunction

  function automatic logic [7:0] pack_exp(input logic [3:0] g, input logic t);
    return {g, |g, onehot_id(g), t};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got grant=%b gv=%b id=%0d to=%b, want grant=%b gv=%b id=%0d to=%b",
               name, act[7:4], act[3], act[2:1], act[0],
               expv[7:4], expv[3], expv[2:1], expv[0]);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] eg, input logic et);
    @(negedge clk);
    req  = r;
    done = d;
    exp_q.push_back(pack_exp(eg, et));
  endtask

  task automatic hold(input int n, input logic [3:0] r, input logic [3:0] eg);
    for (int i = 0; i < n; i++) step(r, 4'b0000, eg, 1'b0);
  endtask

  // Monitor: one expectation per edge at which stimulus queued one
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        check($sformatf("cyc%0d", cyc), {grant, grant_valid, grant_id, timeout}, e);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish, want finish before 20000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    #1 rst = 1'b0;
    #3;
    check("reset", {grant, grant_valid, grant_id, timeout}, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Stray done while idle, then single request
    step(4'b0000, 4'b1111, 4'b0000, 1'b0);
    step(4'b0000, 4'b1111, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    // Owner 2 drops: ptr 3, wraps to requester 0
    step(4'b0001, 4'b0000, 4'b0001, 1'b0);
    // Done with no other requester: re-grant 0, ptr 1
    step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Rotation from ptr 1, done on second granted cycle
    step(4'b1111, 4'b0000, 4'b0010, 1'b0);
    step(4'b1111, 4'b0000, 4'b0010, 1'b0);
    step(4'b1111, 4'b0010, 4'b0100, 1'b0);
    step(4'b1111, 4'b0000, 4'b0100, 1'b0);
    step(4'b1111, 4'b0100, 4'b1000, 1'b0);
    step(4'b1111, 4'b0000, 4'b1000, 1'b0);
    step(4'b1111, 4'b1000, 4'b0001, 1'b0);
    step(4'b1111, 4'b0000, 4'b0001, 1'b0);
    step(4'b1111, 4'b0001, 4'b0010, 1'b0);
    step(4'b1111, 4'b0000, 4'b0010, 1'b0);
    step(4'b1111, 4'b0010, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Lock from ptr 3: owner 0 held 8 cycles, then forced to 1
    step(4'b0011, 4'b0000, 4'b0001, 1'b0);
    hold(7, 4'b0011, 4'b0001);
    step(4'b0011, 4'b0000, 4'b0010, 1'b1);
    step(4'b0011, 4'b0000, 4'b0010, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Sole requester: timeout every 8 cycles, stray done ignored
    step(4'b0001, 4'b0000, 4'b0001, 1'b0);
    hold(3, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0010, 4'b0001, 1'b0);
    hold(3, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    hold(7, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    hold(7, 4'b0001, 4'b0001);
    // Done at the expiry edge suppresses timeout
    step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Move ptr to 3, then grant owner 2 and reset mid-transaction
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    @(negedge clk);
    #2;
    rst  = 1'b0;
    req  = 4'b0000;
    #1;
    check("async_reset", {grant, grant_valid, grant_id, timeout}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1100;
    exp_q.push_back(pack_exp(4'b0100, 1'b0));
    step(4'b1100, 4'b0000, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
